// File: rtl/decode_operand_stage.sv
// Single-entry operand holding stage between decode and issue, with flush and
// optional ROB writeback wakeup of pending sources (macro DECODE_OPERAND_WAKEUP_EN).
module decode_operand_stage #(
    parameter int SRC_CNT = 2,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      snoop_hit,
    input  logic                      bco_valid,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [SRC_CNT*DATA_W-1:0] i_regfs_data,
    input  logic [SRC_CNT-1:0]        i_rat_src_valid,
    input  logic [SRC_CNT*ROB_W-1:0]  i_rat_src_rob,
    input  logic                      wb_valid,
    input  logic [ROB_W-1:0]          wb_rob,
    input  logic [DATA_W-1:0]         wb_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [SRC_CNT*DATA_W-1:0] o_regfs_data,
    output logic [SRC_CNT-1:0]        o_rat_src_valid,
    output logic [SRC_CNT*ROB_W-1:0]  o_rat_src_rob
);

    // Handshake: a bundle moves on any edge where valid and ready are both high;
    // o_ready is the only combinational output, every other output is a flop.
    logic                      valid_q, valid_d;
    logic [SRC_CNT*DATA_W-1:0] data_q, data_d;
    logic [SRC_CNT-1:0]        pend_q, pend_d;
    logic [SRC_CNT*ROB_W-1:0]  rob_q, rob_d;
    logic                      flush;
    logic                      load;

    assign o_ready = !valid_q || i_ready;
    assign flush   = snoop_hit || bco_valid;
    assign load    = i_valid && o_ready && !flush;

`ifdef DECODE_OPERAND_WAKEUP_EN
    logic [SRC_CNT-1:0] hit_in;
    logic [SRC_CNT-1:0] hit_held;

    always_comb begin
        hit_in   = '0;
        hit_held = '0;
        for (int k = 0; k < SRC_CNT; k++) begin
            hit_in[k]   = wb_valid && i_rat_src_valid[k] &&
                          (wb_rob == i_rat_src_rob[k*ROB_W +: ROB_W]);
            hit_held[k] = wb_valid && valid_q && pend_q[k] &&
                          (wb_rob == rob_q[k*ROB_W +: ROB_W]);
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rob, wb_data};
`endif

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pend_d  = pend_q;
        rob_d   = rob_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = i_regfs_data;
            pend_d  = i_rat_src_valid;
            rob_d   = i_rat_src_rob;
`ifdef DECODE_OPERAND_WAKEUP_EN
            // A result broadcast in the load cycle replaces the stale regfile value.
            for (int k = 0; k < SRC_CNT; k++) begin
                if (hit_in[k]) begin
                    data_d[k*DATA_W +: DATA_W] = wb_data;
                    pend_d[k]                  = 1'b0;
                end
            end
`endif
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end else begin
`ifdef DECODE_OPERAND_WAKEUP_EN
            // Tags stay as loaded; only data and the pending flag change on wakeup.
            for (int k = 0; k < SRC_CNT; k++) begin
                if (hit_held[k]) begin
                    data_d[k*DATA_W +: DATA_W] = wb_data;
                    pend_d[k]                  = 1'b0;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pend_q  <= '0;
            rob_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            rob_q   <= rob_d;
        end
    end

    assign o_valid         = valid_q;
    assign o_regfs_data    = data_q;
    assign o_rat_src_valid = pend_q;
    assign o_rat_src_rob   = rob_q;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Bench for decode_operand_stage: directed scenarios plus random traffic, checked
// by a scoreboard fed from a per-source behavioural model (DECODE_OPERAND_WAKEUP_EN aware).
module tb_decode_operand_stage;

    localparam int SRC = 2;
    localparam int DW  = 32;
    localparam int RW  = 4;
    localparam int BW  = SRC*DW + SRC + SRC*RW;
`ifdef DECODE_OPERAND_WAKEUP_EN
    localparam bit WAKE = 1'b1;
`else
    localparam bit WAKE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic              snoop_hit, bco_valid, i_valid, o_ready, wb_valid, o_valid, i_ready;
    logic [SRC*DW-1:0] i_regfs_data, o_regfs_data;
    logic [SRC-1:0]    i_rat_src_valid, o_rat_src_valid;
    logic [SRC*RW-1:0] i_rat_src_rob, o_rat_src_rob;
    logic [RW-1:0]     wb_rob;
    logic [DW-1:0]     wb_data;

    decode_operand_stage #(.SRC_CNT(SRC), .DATA_W(DW), .ROB_W(RW)) dut (
        .clk(clk), .resetn(resetn), .snoop_hit(snoop_hit), .bco_valid(bco_valid),
        .i_valid(i_valid), .o_ready(o_ready), .i_regfs_data(i_regfs_data),
        .i_rat_src_valid(i_rat_src_valid), .i_rat_src_rob(i_rat_src_rob),
        .wb_valid(wb_valid), .wb_rob(wb_rob), .wb_data(wb_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_regfs_data(o_regfs_data),
        .o_rat_src_valid(o_rat_src_valid), .o_rat_src_rob(o_rat_src_rob)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    logic [BW-1:0] exp_q[$];

    // Reference model: the bundle the stage should be presenting, one entry per source.
    bit            m_valid;
    logic [DW-1:0] m_data[SRC];
    logic          m_pend[SRC];
    logic [RW-1:0] m_rob[SRC];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] model_bundle();
        logic [SRC*DW-1:0] d;
        logic [SRC-1:0]    p;
        logic [SRC*RW-1:0] r;
        for (int k = 0; k < SRC; k++) begin
            d[k*DW +: DW] = m_data[k];
            p[k]          = m_pend[k];
            r[k*RW +: RW] = m_rob[k];
        end
        return {d, p, r};
    endfunction

    function automatic logic [BW-1:0] dut_bundle();
        return {o_regfs_data, o_rat_src_valid, o_rat_src_rob};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        for (int k = 0; k < SRC; k++) begin
            m_data[k] = '0;
            m_pend[k] = 1'b0;
            m_rob[k]  = '0;
        end
    endtask

    // What the stage holds after the coming edge, given the inputs now applied.
    task automatic model_step();
        bit wb_on;
        wb_on = WAKE && wb_valid;
        if (snoop_hit || bco_valid) begin
            m_valid = 1'b0;
        end else if (i_valid && (!m_valid || i_ready)) begin
            m_valid = 1'b1;
            for (int k = 0; k < SRC; k++) begin
                m_rob[k] = i_rat_src_rob[k*RW +: RW];
                if (i_rat_src_valid[k] && wb_on && wb_rob == m_rob[k]) begin
                    m_data[k] = wb_data;
                    m_pend[k] = 1'b0;
                end else begin
                    m_data[k] = i_regfs_data[k*DW +: DW];
                    m_pend[k] = i_rat_src_valid[k];
                end
            end
        end else if (m_valid && i_ready) begin
            m_valid = 1'b0;
        end else if (m_valid) begin
            for (int k = 0; k < SRC; k++)
                if (m_pend[k] && wb_on && wb_rob == m_rob[k]) begin
                    m_data[k] = wb_data;
                    m_pend[k] = 1'b0;
                end
        end
    endtask

    // Called at negedge+1 with inputs applied; returns at the next negedge+1.
    task automatic step();
        if (m_valid && i_ready) exp_q.push_back(model_bundle());
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [1:0] pend, input logic [RW-1:0] r0, input logic [RW-1:0] r1);
        i_valid         = v;
        i_regfs_data    = {d1, d0};
        i_rat_src_valid = pend;
        i_rat_src_rob   = {r1, r0};
    endtask

    // Monitor: every accepted output bundle must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (resetn && o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", dut_bundle(), '0);
                end else begin
                    chk("scoreboard_bundle", dut_bundle(), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] exp_d0;
        logic          exp_p0;
        snoop_hit = 0; bco_valid = 0; i_ready = 0;
        wb_valid = 0; wb_rob = '0; wb_data = '0;
        set_in(0, '0, '0, 2'b00, '0, '0);
        model_reset();
        #1 resetn = 1'b0;
        #2;
        chk("reset_o_valid", o_valid, 0);
        chk("reset_o_ready", o_ready, 1);
        chk("reset_bundle", dut_bundle(), '0);
        @(negedge clk);
        #1 resetn = 1'b1;

        // Basic pass-through with a one-cycle latency.
        i_ready = 1;
        set_in(1, 32'h11, 32'h22, 2'b00, '0, '0);
        step();
        chk("basic_o_valid", o_valid, 1);
        chk("basic_data", o_regfs_data, {32'h22, 32'h11});
        set_in(0, '0, '0, 2'b00, '0, '0);
        step();
        chk("basic_drain", o_valid, 0);

        // Stall for three cycles while the inputs keep changing.
        i_ready = 0;
        set_in(1, 32'hA5A5_0001, 32'h5A5A_0002, 2'b00, 4'd1, 4'd2);
        step();
        for (int c = 0; c < 3; c++) begin
            set_in(1, $urandom, $urandom, 2'($urandom), 4'($urandom), 4'($urandom));
            step();
            chk("stall_bundle", dut_bundle(), {32'h5A5A_0002, 32'hA5A5_0001, 2'b00, 4'd2, 4'd1});
            chk("stall_o_ready", o_ready, 0);
        end
        i_ready = 1;
        set_in(0, '0, '0, 2'b00, '0, '0);
        step();
        chk("stall_release", o_valid, 0);

        // Wakeup of a held pending source.
        i_ready = 0;
        set_in(1, 32'h1234, 32'h5678, 2'b01, 4'd5, 4'd9);
        step();
        set_in(0, '0, '0, 2'b00, '0, '0);
        wb_valid = 1; wb_rob = 4'd5; wb_data = 32'hDEAD;
        step();
        wb_valid = 0;
        exp_d0 = WAKE ? 32'hDEAD : 32'h1234;
        exp_p0 = WAKE ? 1'b0 : 1'b1;
        chk("held_wake_data", o_regfs_data[31:0], exp_d0);
        chk("held_wake_pend", o_rat_src_valid[0], exp_p0);
        chk("held_wake_tag", o_rat_src_rob[3:0], 4'd5);
        chk("held_wake_src1", o_regfs_data[63:32], 32'h5678);
        i_ready = 1;
        step();

        // Both sources woken by one broadcast during load.
        set_in(1, 32'hAAAA, 32'hBBBB, 2'b11, 4'd3, 4'd3);
        wb_valid = 1; wb_rob = 4'd3; wb_data = 32'h77;
        step();
        wb_valid = 0;
        chk("load_wake_data", o_regfs_data, WAKE ? {32'h77, 32'h77} : {32'hBBBB, 32'hAAAA});
        chk("load_wake_pend", o_rat_src_valid, WAKE ? 2'b00 : 2'b11);
        set_in(0, '0, '0, 2'b00, '0, '0);
        step();

        // Flush via bco_valid, then via snoop_hit, each with an offered input.
        for (int f = 0; f < 2; f++) begin
            i_ready = 0;
            set_in(1, 32'hC0DE, 32'hBEEF, 2'b00, '0, '0);
            step();
            chk("flush_preload", o_valid, 1);
            if (f == 0) bco_valid = 1; else snoop_hit = 1;
            set_in(1, 32'hF00D, 32'hFACE, 2'b00, '0, '0);
            step();
            bco_valid = 0; snoop_hit = 0;
            chk("flush_o_valid", o_valid, 0);
            set_in(0, '0, '0, 2'b00, '0, '0);
            step();
            chk("flush_no_load", o_valid, 0);
        end

        // Asynchronous reset in the middle of a stall.
        i_ready = 0;
        set_in(1, 32'h9999, 32'h8888, 2'b10, 4'd7, 4'd6);
        step();
        step();
        #2 resetn = 1'b0;
        #1;
        chk("midreset_bundle", dut_bundle(), '0);
        chk("midreset_o_valid", o_valid, 0);
        chk("midreset_o_ready", o_ready, 1);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        #1 resetn = 1'b1;
        i_ready = 1;
        set_in(1, 32'h4444, 32'h3333, 2'b00, '0, '0);
        step();
        chk("postreset_load", o_valid, 1);
        chk("postreset_data", o_regfs_data, {32'h3333, 32'h4444});

        // Random traffic; narrow tag range so broadcasts often hit.
        for (int c = 0; c < 3000; c++) begin
            set_in(($urandom_range(0, 9) < 7), $urandom, $urandom, 2'($urandom),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            i_ready   = ($urandom_range(0, 9) < 6);
            bco_valid = ($urandom_range(0, 19) == 0);
            snoop_hit = ($urandom_range(0, 19) == 0);
            wb_valid  = ($urandom_range(0, 9) < 4);
            wb_rob    = 4'($urandom_range(0, 3));
            wb_data   = $urandom;
            step();
            chk("rand_o_valid", o_valid, m_valid);
            if (m_valid) chk("rand_bundle", dut_bundle(), model_bundle());
        end

        set_in(0, '0, '0, 2'b00, '0, '0);
        i_ready = 1; bco_valid = 0; snoop_hit = 0; wb_valid = 0;
        for (int c = 0; c < 4; c++) step();
        chk("queue_empty", 128'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_operand_stage.md
DECODE_OPERAND_STAGE -- requirements
Module: decode_operand_stage

Interface
REQ-001 The block SHALL have parameter SRC_CNT, default 2, number of source operands.
REQ-002 The block SHALL have parameter DATA_W, default 32, operand data width.
REQ-003 The block SHALL have parameter ROB_W, default 4, ROB tag width.
REQ-004 The block SHALL have a single clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- snoop_hit  in  1  flush request.
- bco_valid  in  1  branch-commit override; flush request.
- i_valid  in  1  upstream operand bundle valid.
- o_ready  out  1  stage can accept the bundle.
- i_regfs_data  in  SRC_CNT*DATA_W  regfile operands; source k occupies bits [k*DATA_W +: DATA_W].
- i_rat_src_valid  in  SRC_CNT  1 = source k is pending on a ROB tag.
- i_rat_src_rob  in  SRC_CNT*ROB_W  pending ROB tags; source k occupies bits [k*ROB_W +: ROB_W].
- wb_valid  in  1  ROB writeback broadcast valid.
- wb_rob  in  ROB_W  writeback ROB tag.
- wb_data  in  DATA_W  writeback result.
- o_valid  out  1  held bundle valid.
- i_ready  in  1  downstream accepts the bundle.
- o_regfs_data  out  SRC_CNT*DATA_W  held operands.
- o_rat_src_valid  out  SRC_CNT  held pending flags.
- o_rat_src_rob  out  SRC_CNT*ROB_W  held ROB tags.

Function
REQ-005 The block SHALL hold one bundle in registers; all outputs except o_ready SHALL be driven directly from flops.
REQ-006 The block SHALL drive o_ready = !o_valid || i_ready, combinationally.
REQ-007 The block SHALL load the input bundle at a clock edge when i_valid && o_ready && no flush, setting o_valid=1; latency is 1 cycle.
REQ-008 The block SHALL clear o_valid when o_valid && i_ready and no load occurs at the same edge.
REQ-009 The block SHALL hold all registers stable while o_valid && !i_ready and no wakeup applies (REQ-011).
REQ-010 The block SHALL, when snoop_hit || bco_valid is high, clear o_valid at the next edge and drop any input offered that cycle; flush SHALL take priority over load and hold.
REQ-011 The block SHALL wake up a held operand: if o_valid && o_rat_src_valid[k] && wb_valid && wb_rob==o_rat_src_rob[k], it SHALL write wb_data into source k's data and clear o_rat_src_valid[k] at the next edge, including while stalled.
REQ-012 The block SHALL wake up an operand on load: if i_rat_src_valid[k] && wb_valid && wb_rob==tag k, it SHALL load wb_data with the pending flag cleared instead of the regfile data.
REQ-013 The block SHALL wake every source whose tag matches a single broadcast, all in the same cycle.
REQ-014 The block SHALL never alter source k's data or tag while its pending flag is 0; the tag field SHALL be held unchanged after wakeup.
REQ-015 The block SHALL ignore wakeups when o_valid=0; register contents are don't-care but stable.

Reset
REQ-016 The block SHALL, on resetn low, asynchronously force o_valid=0, o_regfs_data=0, o_rat_src_valid=0 and o_rat_src_rob=0, so that o_ready=1.
REQ-017 The block SHALL, on reset mid-transfer, discard the bundle, and the first edge after release SHALL behave as from empty.

Configuration
REQ-018 The block SHALL compile the writeback wakeup logic (REQ-011 to REQ-013) only when macro DECODE_OPERAND_WAKEUP_EN is defined.
REQ-019 The block SHALL, without DECODE_OPERAND_WAKEUP_EN, ignore wb_valid, wb_rob and wb_data, and load and hold the bundle unmodified.

Verification
REQ-020 Bench SHALL drive i_valid=1, data0=0x11, data1=0x22, pending=00, with i_ready=1 -> next cycle o_valid=1, o_regfs_data={0x22,0x11}, then o_valid=0 one cycle after i_valid drops.
REQ-021 Bench SHALL load a bundle, hold i_ready=0 for 3 cycles and change the inputs -> outputs are unchanged, o_ready=0, and the bundle is released on i_ready=1.
REQ-022 Bench SHALL hold src0 pending on tag 5 with i_ready=0, then pulse wb_valid, wb_rob=5, wb_data=0xDEAD -> next cycle o_regfs_data[31:0]=0xDEAD, o_rat_src_valid[0]=0, o_rat_src_rob[3:0]=5; with the macro undefined, nothing changes.
REQ-023 Bench SHALL load src0 and src1 both pending on tag 3 with wb_rob=3, wb_data=0x77 in the same cycle -> both data=0x77 and o_rat_src_valid=00.
REQ-024 Bench SHALL assert bco_valid with i_valid=1 while a bundle is held -> next cycle o_valid=0 and the input is not loaded; repeat with snoop_hit.
REQ-025 Bench SHALL assert resetn low asynchronously mid-stall -> all outputs are 0 immediately, o_ready=1, and a load succeeds one cycle after release.
